// File: rtl/consecutive_bit_detector_pkg.sv
// Shared types for the consecutive-bit detector: state encoding and default counter width.
package consecutive_bit_detector_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ZERO  = 3'd1,
        S_ONE   = 3'd2,
        S_DET00 = 3'd3,
        S_DET11 = 3'd4
    } state_t;

    localparam int COUNT_W_DEFAULT = 8;

endpackage

// File: rtl/cbd_sat_counter.sv
// Up-counter that sticks at its all-ones value; used for the optional detection counts.
module cbd_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/consecutive_bit_detector.sv
// Moore detector for two equal consecutive button-entered bits ("00" / "11").
// Define CBD_HIT_COUNT_EN to add saturating detection counters (count_00, count_11).
//
// state   | meaning
// S_IDLE  | no bit since reset
// S_ZERO  | last bit 0, previous differs or absent
// S_ONE   | last bit 1, previous differs or absent
// S_DET00 | last two bits 0,0
// S_DET11 | last two bits 1,1
module consecutive_bit_detector
    import consecutive_bit_detector_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn0_pulse,
    input  logic               btn2_pulse,
    output logic               detected_00,
    output logic               detected_11
`ifdef CBD_HIT_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count_00,
    output logic [COUNT_W-1:0] count_11
`endif
);

    state_t state;
    state_t next_state;
    logic   bit0;
    logic   bit1;

    // Simultaneous strobes are ambiguous and are dropped.
    assign bit0 = btn0_pulse & ~btn2_pulse;
    assign bit1 = btn2_pulse & ~btn0_pulse;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bit0)      next_state = S_ZERO;
                else if (bit1) next_state = S_ONE;
            end
            S_ZERO: begin
                if (bit0)      next_state = S_DET00;
                else if (bit1) next_state = S_ONE;
            end
            S_ONE: begin
                if (bit0)      next_state = S_ZERO;
                else if (bit1) next_state = S_DET11;
            end
            S_DET00: begin
                if (bit1)      next_state = S_ONE;
            end
            S_DET11: begin
                if (bit0)      next_state = S_ZERO;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            detected_00 <= 1'b0;
            detected_11 <= 1'b0;
        end else begin
            state       <= next_state;
            detected_00 <= (next_state == S_DET00);
            detected_11 <= (next_state == S_DET11);
        end
    end

    if (COUNT_W < 1) begin : g_count_w_invalid
        // COUNT_W is only consumed by the optional counters; a non-positive width is unusable.
    end

`ifdef CBD_HIT_COUNT_EN
    // Only accepted bits count, so an idle S_DET00 does not keep incrementing.
    cbd_sat_counter #(.W(COUNT_W)) u_count_00 (
        .clk   (clk),
        .reset (reset),
        .inc   (bit0 && (next_state == S_DET00)),
        .count (count_00)
    );

    cbd_sat_counter #(.W(COUNT_W)) u_count_11 (
        .clk   (clk),
        .reset (reset),
        .inc   (bit1 && (next_state == S_DET11)),
        .count (count_11)
    );
`endif

endmodule

// File: tb/tb_consecutive_bit_detector.sv
// Bench for consecutive_bit_detector: directed scenarios plus random strobes vs a bit-history model.
module tb_consecutive_bit_detector;

    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset;
    logic btn0_pulse;
    logic btn2_pulse;
    logic detected_00;
    logic detected_11;
`ifdef CBD_HIT_COUNT_EN
    logic [CW-1:0] count_00;
    logic [CW-1:0] count_11;
`endif

    int total = 0;
    int bad   = 0;

    // Model: the last two accepted bits and how many bits arrived since reset.
    int hist_n   = 0;
    int last_bit = 0;
    int prev_bit = 0;
    int m_cnt00  = 0;
    int m_cnt11  = 0;

    consecutive_bit_detector #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn0_pulse  (btn0_pulse),
        .btn2_pulse  (btn2_pulse),
        .detected_00 (detected_00),
        .detected_11 (detected_11)
`ifdef CBD_HIT_COUNT_EN
        ,
        .count_00    (count_00),
        .count_11    (count_11)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit exp00();
        return (hist_n >= 2) && (prev_bit == 0) && (last_bit == 0);
    endfunction

    function automatic bit exp11();
        return (hist_n >= 2) && (prev_bit == 1) && (last_bit == 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_n  = 0;
            m_cnt00 = 0;
            m_cnt11 = 0;
        end else if (btn0_pulse != btn2_pulse) begin
            prev_bit = last_bit;
            last_bit = btn2_pulse ? 1 : 0;
            hist_n   = hist_n + 1;
            if (exp00() && m_cnt00 < (1 << CW) - 1) m_cnt00 = m_cnt00 + 1;
            if (exp11() && m_cnt11 < (1 << CW) - 1) m_cnt11 = m_cnt11 + 1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_det00", int'(detected_00), int'(exp00()));
        check("model_det11", int'(detected_11), int'(exp11()));
        check("one_hot", int'(detected_00 & detected_11), 0);
`ifdef CBD_HIT_COUNT_EN
        check("model_cnt00", int'(count_00), m_cnt00);
        check("model_cnt11", int'(count_11), m_cnt11);
`endif
    end

    // k: 0 = bit 0, 1 = bit 1, 2 = both strobes, 3 = no strobe
    task automatic send(input int k);
        @(negedge clk);
        btn0_pulse = (k == 0) || (k == 2);
        btn2_pulse = (k == 1) || (k == 2);
        @(posedge clk);
        #1;
        btn0_pulse = 1'b0;
        btn2_pulse = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        btn0_pulse = 1'b0;
        btn2_pulse = 1'b0;
        #2;
        check("reset_det00", int'(detected_00), 0);
        check("reset_det11", int'(detected_11), 0);
        #18;
        reset = 1'b0;

        // 1,0,0
        send(1); check("s1_b1_det11", int'(detected_11), 0);
        send(0); check("s1_b2_det00", int'(detected_00), 0);
        send(0); check("s1_b3_det00", int'(detected_00), 1);
        check("s1_b3_det11", int'(detected_11), 0);
        send(3); check("s1_hold_det00", int'(detected_00), 1);

        // from DET00: 1,1
        send(1); check("s2_b1_det00", int'(detected_00), 0);
        check("s2_b1_det11", int'(detected_11), 0);
        send(1); check("s2_b2_det11", int'(detected_11), 1);
        send(3); send(3); check("s2_hold_det11", int'(detected_11), 1);

        // 0,1,1 then 0,0,0
        send(0); check("s3_b1_det11", int'(detected_11), 0);
        send(1); send(1); check("s3_11", int'(detected_11), 1);
        send(0); check("s3_0a", int'(detected_00), 0);
        send(0); check("s3_0b", int'(detected_00), 1);
        send(0); check("s3_0c", int'(detected_00), 1);

        // both strobes ignored
        send(2); check("s4_both_det00", int'(detected_00), 1);
        check("s4_both_det11", int'(detected_11), 0);
        send(1); send(2); send(1); check("s4_state_held", int'(detected_11), 1);

        // async reset while detected_11 is high
        #2;
        reset = 1'b1;
        #1;
        check("s5_async_det11", int'(detected_11), 0);
        @(negedge clk);
        reset = 1'b0;
        send(1); check("s5_first_bit", int'(detected_11), 0);

`ifdef CBD_HIT_COUNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) send(0);
        check("s6_cnt00_sat", int'(count_00), 3);
        check("s6_cnt11", int'(count_11), 0);
`endif

        // random strobes, weighted toward single bits
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)       send(0);
            else if (r < 8)  send(1);
            else if (r == 8) send(2);
            else             send(3);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                check("rand_async_det00", int'(detected_00), 0);
                check("rand_async_det11", int'(detected_11), 0);
                @(negedge clk);
                reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
